// File: rtl/npu_loader_pkg.sv
// Shared encodings for the NPU stream loader: section selects, control ops, FSM states.
// NPU_LOADER_CKSUM_EN adds the checksum state to the FSM.
package npu_loader_pkg;

  localparam logic [2:0] SEL_IMG  = 3'd0;
  localparam logic [2:0] SEL_WC1  = 3'd1;
  localparam logic [2:0] SEL_WC2  = 3'd2;
  localparam logic [2:0] SEL_FC1  = 3'd3;
  localparam logic [2:0] SEL_FC2  = 3'd4;
  localparam logic [2:0] SEL_CTRL = 3'd5;

  localparam logic [7:0] OP_RST     = 8'd0;
  localparam logic [7:0] OP_TRIGGER = 8'd1;
  localparam logic [7:0] OP_REQUIRE = 8'd2;

`ifdef NPU_LOADER_CKSUM_EN
  typedef enum logic [2:0] {StHdr, StPay, StOp, StRd, StRdWait, StResp, StCk} state_e;
`else
  typedef enum logic [2:0] {StHdr, StPay, StOp, StRd, StRdWait, StResp} state_e;
`endif

endpackage

// File: rtl/npu_word_packer.sv
// Packs payload bytes little-endian into 32-bit words; emits a one-cycle write pulse
// with the finished word, zero-filling lanes not written before a section ends.
module npu_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        valid,
  input  logic        last,
  output logic [31:0] word,
  output logic        wr
);

  logic [1:0]  lane_q;
  logic [23:0] acc_q;
  logic [31:0] word_q;
  logic        wr_q;
  logic [31:0] merged;

  // acc_q is cleared after every word, so lanes above the current one are already zero
  always_comb begin
    merged = {8'h00, acc_q} | ({24'h000000, data} << {lane_q, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= 2'd0;
      acc_q  <= 24'h0;
      word_q <= 32'h0;
      wr_q   <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      word_q <= 32'h0;
      if (valid) begin
        if (lane_q == 2'd3 || last) begin
          word_q <= merged;
          wr_q   <= 1'b1;
          lane_q <= 2'd0;
          acc_q  <= 24'h0;
        end else begin
          acc_q  <= merged[23:0];
          lane_q <= lane_q + 2'd1;
        end
      end
    end
  end

  assign word = word_q;
  assign wr   = wr_q;

endmodule

// File: rtl/npu_stream_loader.sv
// Host byte-stream to NPU write-port bridge with control ops and logit readback.
// Define NPU_LOADER_CKSUM_EN to require a mod-256 checksum byte after each payload section.
module npu_stream_loader
  import npu_loader_pkg::*;
#(
  parameter int unsigned IMG_BYTES = 240,
  parameter int unsigned WC_BYTES  = 90,
  parameter int unsigned FC1_BYTES = 1320,
  parameter int unsigned FC2_BYTES = 10,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        busy,
  output logic [1:0]  err
);

  function automatic logic [11:0] sec_len(input logic [2:0] sel);
    case (sel)
      SEL_IMG:          sec_len = 12'(IMG_BYTES);
      SEL_WC1, SEL_WC2: sec_len = 12'(WC_BYTES);
      SEL_FC1:          sec_len = 12'(FC1_BYTES);
      SEL_FC2:          sec_len = 12'(FC2_BYTES);
      default:          sec_len = 12'd0;
    endcase
  endfunction

  state_e      state_q;
  logic [2:0]  sel_q;
  logic [11:0] len_q;
  logic [11:0] cnt_q;
  logic [1:0]  lat_q;
  logic        ena_q;
  logic        wea_q;
  logic [15:0] addra_q;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic        err_hdr_q;
`ifdef NPU_LOADER_CKSUM_EN
  logic [7:0]  sum_q;
  logic        err_ck_q;
`endif

  logic        acc;
  logic        pay_acc;
  logic        pay_last;
  logic [31:0] pk_word;
  logic        pk_wr;

  assign s_ready  = !(state_q == StRd || state_q == StRdWait || state_q == StResp);
  assign acc      = s_valid && s_ready;
  assign pay_acc  = acc && (state_q == StPay);
  assign pay_last = (cnt_q == len_q - 12'd1);

  npu_word_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .data  (s_data),
    .valid (pay_acc),
    .last  (pay_last),
    .word  (pk_word),
    .wr    (pk_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHdr;
      sel_q     <= 3'd0;
      len_q     <= 12'd0;
      cnt_q     <= 12'd0;
      lat_q     <= 2'd0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      addra_q   <= 16'h0;
      m_valid_q <= 1'b0;
      m_data_q  <= 32'h0;
      err_hdr_q <= 1'b0;
`ifdef NPU_LOADER_CKSUM_EN
      sum_q     <= 8'h0;
      err_ck_q  <= 1'b0;
`endif
    end else begin
      ena_q <= 1'b0;
      wea_q <= 1'b0;
      unique case (state_q)
        StHdr: if (acc) begin
          if (s_data[2:0] <= SEL_FC2) begin
            sel_q   <= s_data[2:0];
            len_q   <= sec_len(s_data[2:0]);
            cnt_q   <= 12'd0;
`ifdef NPU_LOADER_CKSUM_EN
            sum_q   <= 8'h0;
`endif
            state_q <= StPay;
          end else if (s_data[2:0] == SEL_CTRL) begin
            state_q <= StOp;
          end else begin
            err_hdr_q <= 1'b1;
          end
        end
        StPay: if (acc) begin
          cnt_q <= cnt_q + 12'd1;
`ifdef NPU_LOADER_CKSUM_EN
          sum_q <= sum_q + s_data;
`endif
          // The packer issues the write strobe; the word index is the byte count / 4
          if (pay_last || cnt_q[1:0] == 2'd3) begin
            addra_q <= {1'b0, sel_q, 2'b00, cnt_q[11:2]};
          end
          if (pay_last) begin
`ifdef NPU_LOADER_CKSUM_EN
            state_q <= StCk;
`else
            state_q <= StHdr;
`endif
          end
        end
        StOp: if (acc) begin
          if (s_data == OP_RST || s_data == OP_TRIGGER) begin
            ena_q   <= 1'b1;
            wea_q   <= 1'b1;
            addra_q <= {1'b0, SEL_CTRL, 4'h0, s_data};
            state_q <= StHdr;
          end else if (s_data == OP_REQUIRE) begin
            ena_q   <= 1'b1;
            addra_q <= {1'b0, SEL_CTRL, 4'h0, OP_REQUIRE};
            state_q <= StRd;
          end else begin
            state_q <= StHdr;
          end
        end
        StRd: begin
          lat_q   <= 2'd1;
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (lat_q == 2'(RD_LAT)) begin
            m_data_q  <= douta;
            m_valid_q <= 1'b1;
            state_q   <= StResp;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        StResp: if (m_ready) begin
          m_valid_q <= 1'b0;
          state_q   <= StHdr;
        end
`ifdef NPU_LOADER_CKSUM_EN
        StCk: if (acc) begin
          if (s_data != sum_q) err_ck_q <= 1'b1;
          state_q <= StHdr;
        end
`endif
        default: state_q <= StHdr;
      endcase
    end
  end

  assign ena     = ena_q | pk_wr;
  assign wea     = wea_q | pk_wr;
  assign addra   = addra_q;
  assign dina    = pk_word;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state_q != StHdr);
`ifdef NPU_LOADER_CKSUM_EN
  assign err     = {err_ck_q, err_hdr_q};
`else
  assign err     = {1'b0, err_hdr_q};
`endif

endmodule

// File: tb/tb_npu_stream_loader.sv
// Directed bench for npu_stream_loader with a small NPU port model (RD_LAT = 1).
module tb_npu_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        busy;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          rd_cnt = 0;
  logic [15:0] rd_addr = 16'h0;

  always #5 clk = ~clk;

  npu_stream_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .ena     (ena),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy),
    .err     (err)
  );

  // Logit appears only one cycle after a read of 0x5002; garbage otherwise
  always @(posedge clk) begin
    douta <= (ena && !wea && addra == 16'h5002) ? 32'h00FFFF85 : 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (ena) begin
      if (wea) begin
        wr_addr.push_back(addra);
        wr_data.push_back(dina);
      end else begin
        rd_cnt  = rd_cnt + 1;
        rd_addr = addra;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("send_timeout", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] hdr, input int n, input logic [7:0] start,
                      input logic [7:0] ck_delta);
    logic [7:0] sum = 8'h00;
    send_byte(hdr);
    for (int i = 0; i < n; i++) begin
      send_byte(start + 8'(i));
      sum = sum + start + 8'(i);
    end
`ifdef NPU_LOADER_CKSUM_EN
    send_byte(sum + ck_delta);
`else
    if (ck_delta != 8'h00) sum = 8'h00;
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rd_cnt = 0;
  endtask

  task automatic check_fc2(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check({tag, "_a0"}, {16'h0, wr_addr[0]}, 32'h4000);
      check({tag, "_d0"}, wr_data[0], 32'h04030201);
      check({tag, "_a1"}, {16'h0, wr_addr[1]}, 32'h4001);
      check({tag, "_d1"}, wr_data[1], 32'h08070605);
      check({tag, "_a2"}, {16'h0, wr_addr[2]}, 32'h4002);
      check({tag, "_d2"}, wr_data[2], 32'h00000A09);
    end
  endtask

  initial begin
    int waited;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check("rst_ena", {31'b0, ena}, 32'd0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {30'b0, err}, 32'd0);
    check("rst_addra", {16'h0, addra}, 32'd0);
    check("rst_m_data", m_data, 32'd0);

    // FC2 section
    clear_log();
    load(8'h04, 10, 8'h01, 8'h00);
    check_fc2("fc2");
    check("fc2_busy", {31'b0, busy}, 32'd0);
    check("fc2_err", {30'b0, err}, 32'd0);

    // Trigger op
    clear_log();
    send_byte(8'h05);
    send_byte(8'h01);
    @(negedge clk);
    check("trig_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("trig_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("trig_addr", {16'h0, wr_addr[0]}, 32'h5001);
      check("trig_data", wr_data[0], 32'h0);
    end

    // Require op with stalled consumer
    clear_log();
    send_byte(8'h05);
    send_byte(8'h02);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!m_valid && waited < 10);
    check("req_latency", 32'(waited), 32'd3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("req_m_valid", {31'b0, m_valid}, 32'd1);
      check("req_m_data", m_data, 32'h00FFFF85);
      check("req_s_ready", {31'b0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("req_drop", {31'b0, m_valid}, 32'd0);
    check("req_busy", {31'b0, busy}, 32'd0);
    check("req_nrd", 32'(rd_cnt), 32'd1);
    check("req_raddr", {16'h0, rd_addr}, 32'h5002);
    check("req_nwr", 32'(wr_addr.size()), 32'd0);

    // Bad header, then a normal section
    clear_log();
    send_byte(8'h07);
    repeat (3) @(negedge clk);
    check("badhdr_err", {30'b0, err}, 32'd1);
    check("badhdr_acc", 32'(wr_addr.size() + rd_cnt), 32'd0);
    load(8'h04, 10, 8'h01, 8'h00);
    check_fc2("after_bad");
    check("after_bad_err", {30'b0, err}, 32'd1);

    // Reset in the middle of an image load
    send_byte(8'h00);
    for (int i = 0; i < 100; i++) send_byte(8'(i));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    check("midrst_err", {30'b0, err}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_nwr", 32'(wr_addr.size()), 32'd0);

    load(8'h00, 240, 8'h00, 8'h00);
    check("img_nwr", 32'(wr_addr.size()), 32'd60);
    if (wr_addr.size() == 60) begin
      for (int w = 0; w < 60; w++) begin
        check("img_addr", {16'h0, wr_addr[w]}, 32'(w));
        check("img_data", wr_data[w],
              {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
      end
    end

`ifdef NPU_LOADER_CKSUM_EN
    clear_log();
    load(8'h04, 10, 8'h01, 8'h00);
    check("ck_ok_err", {31'b0, err[1]}, 32'd0);
    check_fc2("ck_ok");
    clear_log();
    load(8'h04, 10, 8'h01, 8'h01);
    check("ck_bad_err", {31'b0, err[1]}, 32'd1);
    check_fc2("ck_bad");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_stream_loader.md
Name: npu_stream_loader

Overview:
- Upstream host-side feeder for the NPU core.
- Accepts a framed byte stream from the host using valid/ready, and turns it into the NPU's 32-bit write-port transactions (ena/wea/addra/dina).
- Issues control ops (rst, trigger, require) as writes to the section-5 address space.
- For require, reads the logit back on douta and returns it on a 32-bit valid/ready result stream.

Parameters:
IMG_BYTES, 240, input image length in bytes (16x15)
WC_BYTES, 90, conv1/conv2 weight length in bytes each (3x3x10)
FC1_BYTES, 1320, fc1 weight length in bytes (132x10)
FC2_BYTES, 10, fc2 weight length in bytes
RD_LAT, 1, cycles from read request (ena=1, wea=0) to valid douta; range 1..3

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  host byte valid
s_ready  out  1  loader can accept byte
s_data  in  8  host byte
ena  out  1  NPU port enable
wea  out  1  NPU write enable
addra  out  16  NPU address: [15]=0, [14:12]=sel, [11:0]=word idx or op
dina  out  32  NPU write data
douta  in  32  NPU read data
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  32  result word (douta captured)
busy  out  1  high whenever FSM is not in S_HDR
err  out  2  sticky: [0] bad header sel, [1] checksum mismatch

Behaviour:
- Reset values (rst=1 at clk edge): all outputs 0 except s_ready=1. FSM goes to S_HDR, all counters reset, any partial word is discarded. A reset mid-operation aborts the operation with no further NPU access. err clears only on rst.
- Byte accept: a byte is accepted when s_valid && s_ready. s_ready=1 in S_HDR, S_OP and S_PAY; s_ready=0 in S_RD, S_RD_WAIT and S_RESP.
- S_HDR (header byte): sel = s_data[2:0].
  - sel 0..4: latch section length (0:IMG, 1/2:WC, 3:FC1, 4:FC2), go to S_PAY.
  - sel 5: go to S_OP.
  - sel 6/7: set err[0], stay in S_HDR.
  - Header bits [7:3] are ignored.
- S_PAY: bytes are packed little-endian; byte k of a word lands in dina[8k+7:8k].
  - A write issues on the cycle after the accepted byte that either completes a word or is the last byte of the section.
  - That write drives ena=1, wea=1, addra={1'b0, sel, widx}, with unfilled bytes zeroed.
  - widx starts at 0 per section and increments after each write. Maximum one write per cycle; no backpressure from the NPU.
  - After the last byte: go to S_HDR (or S_CK under the optional feature).
- S_OP: the op byte is accepted.
  - Op 0 or 1: one write next cycle, addra={1'b0, 3'b101, 4'h0, op}, dina=0; then S_HDR.
  - Op 2: go to S_RD.
  - Op >2: ignored, return to S_HDR; err is not set.
- S_RD: one cycle with ena=1, wea=0, addra=16'h5002; go to S_RD_WAIT.
- S_RD_WAIT: count RD_LAT cycles from the request, then capture douta into m_data and go to S_RESP with m_valid=1.
- S_RESP: m_valid and m_data are held stable until m_ready. The cycle m_valid && m_ready: m_valid drops next cycle, FSM goes to S_HDR. m_ready high on the first valid cycle completes in 1 cycle.
- ena/wea are single-cycle pulses; they are 0 in all other cycles.
- Simultaneous events: a new header cannot arrive during S_RESP because s_ready=0.

Optional Feature:
- NPU_LOADER_CKSUM_EN defined:
  - Each payload section is followed by one checksum byte, consumed in state S_CK.
  - Expected value = 8-bit modulo-256 sum of the section's payload bytes.
  - Mismatch sets err[1]. Payload writes have already been issued and are not undone.
  - S_CK then goes to S_HDR.
- Not defined: no S_CK state, no checksum byte, err[1] tied 0.

Decomposition:
- Package npu_loader_pkg holds:
  - sel encoding constants (SEL_IMG=0, SEL_WC1=1, SEL_WC2=2, SEL_FC1=3, SEL_FC2=4, SEL_CTRL=5);
  - op codes (OP_RST=0, OP_TRIGGER=1, OP_REQUIRE=2);
  - the FSM state enum.
- Sub-module npu_word_packer: byte-lane shift register plus lane counter. Inputs: byte, valid, last. Outputs: word and a write pulse, with zero-fill of unfilled bytes.

Test Plan:
- FC2 load: header 0x04, bytes 0x01..0x0A -> 3 writes:
  - addra 0x4000 / dina 0x04030201
  - addra 0x4001 / dina 0x08070605
  - addra 0x4002 / dina 0x00000A09
- Trigger: bytes 0x05, 0x01 -> exactly one write, addra 0x5001, dina 0; busy returns 0 the next cycle.
- Require (RD_LAT=1):
  - Stimulus: bytes 0x05, 0x02; douta=0x00FFFF85; m_ready held low 3 cycles.
  - Response: one read at addra 0x5002; m_data=0x00FFFF85 stable for 4 cycles, then m_valid drops; s_ready=0 throughout.
- Bad header: byte 0x07 -> err=2'b01, no NPU access; a following 0x04 section loads normally.
- Reset during image load after 100 bytes -> no writes after reset; a fresh full 240-byte load gives 60 writes, addra 0x0000..0x003B.
- With NPU_LOADER_CKSUM_EN: FC2 load, bytes 0x01..0x0A, checksum 0x37 -> err[1]=0. Repeat with checksum 0x38 -> err[1]=1, 3 writes still issued.
